uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 115, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 SHALL provide parameter PARITY_MODE, default 0, parity selection: 0 none, 1 odd, 2 even.
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL provide parameter FIFO_DEPTH, default 4, input FIFO entries (power of 2, 2..16); it is used only when UART_TX_FIFO_EN is defined.
REQ-006 SHALL have port i_Clock, input, 1 bit, the single clock; all logic is synchronous to its rising edge.
REQ-007 SHALL have port i_Reset, input, 1 bit, reset, asynchronous, active-high.
REQ-008 SHALL have port i_Tx_DV, input, 1 bit, data-valid strobe.
REQ-009 SHALL have port i_Tx_Byte, input, DATA_BITS wide, word to send.
REQ-010 SHALL have port o_Tx_Ready, output, 1 bit, high when a word will be accepted this cycle.
REQ-011 SHALL have port o_Tx_Serial, output, 1 bit, serial line, which idles high.
REQ-012 SHALL have port o_Tx_Active, output, 1 bit, high from the first start-bit cycle through the last stop-bit cycle.
REQ-013 SHALL have port o_Tx_Done, output, 1 bit, one-cycle pulse marking the end of each frame.

Function
REQ-014 A word SHALL be accepted only in a cycle where i_Tx_DV=1 and o_Tx_Ready=1.
REQ-015 When i_Tx_DV=1 and o_Tx_Ready=0, the word SHALL be dropped with no state change.
REQ-016 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and CLEANUP; any unused encoding SHALL return to IDLE.
REQ-017 Transition IDLE->START SHALL occur when a word is available (accepted this cycle, or FIFO non-empty); the word is latched into the shift register at that edge.
REQ-018 START SHALL drive 0 for exactly CLKS_PER_BIT cycles, beginning on the cycle after the transition.
REQ-019 DATA SHALL drive DATA_BITS bits LSB first, each held for CLKS_PER_BIT cycles.
REQ-020 PARITY SHALL be entered only when PARITY_MODE!=0 and SHALL drive one bit for CLKS_PER_BIT cycles.
REQ-021 The parity bit SHALL make the total count of ones in data plus parity odd (mode 1) or even (mode 2).
REQ-022 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 CLEANUP SHALL last 1 cycle with o_Tx_Serial=1 and o_Tx_Done=1, then go to IDLE.
REQ-024 The bit-time counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL clear on every bit boundary; wrap-around is not permitted.
REQ-025 Frame length, from the first start-bit cycle through CLEANUP, SHALL be CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS)+1 cycles, where P=1 if parity is enabled, else 0.
REQ-026 o_Tx_Serial SHALL be registered, with no combinational path from any input.
REQ-027 o_Tx_Active SHALL fall in the cycle CLEANUP is entered.

Reset
REQ-028 While i_Reset=1, the block SHALL force state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, all counters to 0, and the FIFO empty.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, without a completion pulse.
REQ-030 o_Tx_Ready SHALL be 0 while i_Reset=1, and SHALL be 1 on the first clock edge after release.

Configuration
REQ-031 Macro UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry input FIFO SHALL be instantiated.
REQ-032 With UART_TX_FIFO_EN defined, o_Tx_Ready SHALL equal not-full.
REQ-033 With UART_TX_FIFO_EN defined, a write and a read in the same cycle SHALL be allowed when full: the read frees a slot and the write is accepted.
REQ-034 With UART_TX_FIFO_EN defined, back-to-back frames SHALL be separated only by the CLEANUP and IDLE cycles (2 cycles of line high beyond the stop bits).
REQ-035 Macro UART_TX_FIFO_EN undefined: no FIFO SHALL exist, o_Tx_Ready SHALL equal (state==IDLE), and i_Tx_DV outside IDLE SHALL be ignored.

Verification
REQ-036 CLKS_PER_BIT=4, DATA_BITS=8, no parity, 1 stop, send 0xA5 -> line shows 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles, and o_Tx_Done pulses exactly 41 cycles after the start bit begins.
REQ-037 Same configuration with PARITY_MODE=2, send 0xA5 -> parity bit 0; with PARITY_MODE=1 -> parity bit 1; frame length 45 cycles.
REQ-038 DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, send 0x7F -> start bit, seven 1 bits, then stop held high for 8 cycles; o_Tx_Done at cycle 41.
REQ-039 i_Reset pulsed during bit 3 of a frame -> o_Tx_Serial=1 in the same cycle, o_Tx_Done never pulses, and the next word is accepted normally.
REQ-040 FIFO enabled, FIFO_DEPTH=4: push 6 words back-to-back -> words 1-5 are accepted (one leaves for the shifter), word 6 is dropped with o_Tx_Ready=0, and 5 frames are sent in order.
REQ-041 FIFO disabled: pulse i_Tx_DV mid-frame with 0x3C -> the word is ignored and only the original frame is transmitted.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter with optional input FIFO.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
//
// Ports:
//   i_Clock     - single clock, rising edge
//   i_Reset     - asynchronous active-high reset
//   i_Tx_DV     - data-valid strobe, word taken when o_Tx_Ready is also high
//   i_Tx_Byte   - DATA_BITS-wide word to send
//   o_Tx_Ready  - a word presented this cycle will be accepted
//   o_Tx_Serial - registered serial line, idles high
//   o_Tx_Active - high from first start-bit cycle through last stop-bit cycle
//   o_Tx_Done   - one-cycle pulse in the CLEANUP cycle that ends each frame
//
// Build option: define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry input FIFO.

module uart_tx_param #(
    parameter int CLKS_PER_BIT = 115,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    localparam logic PAR_EN  = (PARITY_MODE != 0);
    localparam logic PAR_ODD = (PARITY_MODE == 1);

    // Elaboration-time parameter legality checks.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT out of range");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_tx_param: DATA_BITS out of range");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_pm
        $error("uart_tx_param: PARITY_MODE out of range");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_tx_param: STOP_BITS out of range");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
        $error("uart_tx_param: FIFO_DEPTH must be a power of 2 in 2..16");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 rdy_en;

    // Word source feeding the shifter, either the FIFO head or the port.
    logic                 word_avail;
    logic [DATA_BITS-1:0] word;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 wr_en;
    logic                 rd_en;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd_en = (state == S_IDLE) && !empty;

    // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
    assign o_Tx_Ready = rdy_en && (!full || rd_en);
    assign wr_en      = i_Tx_DV && o_Tx_Ready;

    assign word_avail = rd_en;
    assign word       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
`else
    assign o_Tx_Ready = rdy_en && (state == S_IDLE);
    assign word_avail = i_Tx_DV && o_Tx_Ready;
    assign word       = i_Tx_Byte;
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            rdy_en      <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            o_Tx_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    if (word_avail) begin
                        shift       <= word;
                        par_bit     <= (^word) ^ PAR_ODD;
                        state       <= S_START;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                    end
                end
                S_START: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt     <= '0;
                        state       <= S_DATA;
                        o_Tx_Serial <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PAR_EN) begin
                                state       <= S_PARITY;
                                o_Tx_Serial <= par_bit;
                            end else begin
                                state       <= S_STOP;
                                o_Tx_Serial <= 1'b1;
                            end
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            shift       <= shift >> 1;
                            o_Tx_Serial <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt     <= '0;
                        state       <= S_STOP;
                        o_Tx_Serial <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // bit_idx is reused to count stop bits.
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx     <= '0;
                            state       <= S_CLEANUP;
                            o_Tx_Serial <= 1'b1;
                            o_Tx_Active <= 1'b0;
                            o_Tx_Done   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_CLEANUP: begin
                    state       <= S_IDLE;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed self-checking bench for uart_tx_param.
// Four instances cover no parity, even, odd, and 7-bit/2-stop framing.

module tb_uart_tx_param;

    localparam int CPB = 4;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dv;
    logic [7:0] tx_byte;
    logic [3:0] ser;
    logic [3:0] done;
    logic [3:0] act;
    logic [3:0] rdy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u0 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]),
        .i_Tx_Byte(tx_byte), .o_Tx_Ready(rdy[0]),
        .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(done[0])
    );

    uart_tx_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]),
        .i_Tx_Byte(tx_byte), .o_Tx_Ready(rdy[1]),
        .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(done[1])
    );

    uart_tx_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]),
        .i_Tx_Byte(tx_byte), .o_Tx_Ready(rdy[2]),
        .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(done[2])
    );

    uart_tx_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u3 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]),
        .i_Tx_Byte(tx_byte[6:0]), .o_Tx_Ready(rdy[3]),
        .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(done[3])
    );

    // Expected per-cycle line for a frame whose bit k (start = bit 0)
    // is bits[k], nb bits long, starting LAT samples into the window.
    function automatic logic [55:0] exp_ser(input logic [15:0] bits,
                                            input int nb);
        logic [55:0] v;
        int i;
        for (int c = 0; c < 56; c++) begin
            i = c - LAT;
            v[c] = (i >= 0 && i < CPB * nb) ? bits[i / CPB] : 1'b1;
        end
        return v;
    endfunction

    function automatic logic [55:0] exp_done(input int nb);
        logic [55:0] v;
        for (int c = 0; c < 56; c++) begin
            v[c] = ((c - LAT) == CPB * nb);
        end
        return v;
    endfunction

    function automatic logic [55:0] exp_act(input int nb);
        logic [55:0] v;
        for (int c = 0; c < 56; c++) begin
            v[c] = ((c - LAT) >= 0) && ((c - LAT) < CPB * nb);
        end
        return v;
    endfunction

    // Present one word to instance k, then record 56 cycles of outputs.
    // Optionally strobe i_Tx_DV with a second word at sample inj_at.
    task automatic capture(input int k, input logic [7:0] data,
                           input int inj_at, input logic [7:0] inj,
                           output logic [55:0] sv, output logic [55:0] dn,
                           output logic [55:0] ac, output logic [55:0] rv,
                           output logic acc);
        int w;
        w = 0;
        acc = 1'b0;
        @(negedge clk);
        while (!rdy[k] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (rdy[k]) begin
            acc = 1'b1;
            dv[k] = 1'b1;
            tx_byte = data;
        end
        @(posedge clk);
        @(negedge clk);
        dv[k] = 1'b0;
        for (int c = 0; c < 56; c++) begin
            sv[c] = ser[k];
            dn[c] = done[k];
            ac[c] = act[k];
            rv[c] = rdy[k];
            if (c == inj_at) begin
                dv[k] = 1'b1;
                tx_byte = inj;
            end else begin
                dv[k] = 1'b0;
            end
            @(negedge clk);
        end
        dv[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dv = 4'h0;
        tx_byte = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (ser !== 4'hF)
            $display("FAIL reset_serial got=%b exp=1111", ser);
        if (ser !== 4'hF) failures++;
        checks++;
        if (act !== 4'h0 || done !== 4'h0) begin
            $display("FAIL reset_act_done act=%b done=%b exp=0000", act, done);
            failures++;
        end
        checks++;
        if (rdy !== 4'h0) begin
            $display("FAIL reset_ready got=%b exp=0000", rdy);
            failures++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rdy !== 4'hF) begin
            $display("FAIL ready_after_release got=%b exp=1111", rdy);
            failures++;
        end
    endtask

    task automatic test_basic;
        logic [55:0] sv, dn, ac, rv, e;
        logic acc;
        capture(0, 8'hA5, -1, 8'h00, sv, dn, ac, rv, acc);
        checks++;
        if (acc !== 1'b1) begin
            $display("FAIL basic_accept got=%b exp=1", acc);
            failures++;
        end
        // 0,1,0,1,0,0,1,0,1,1 on the line
        e = exp_ser(16'h034A, 10);
        checks++;
        if (sv !== e) begin
            $display("FAIL basic_line got=%h exp=%h", sv, e);
            failures++;
        end
        e = exp_done(10);
        checks++;
        if (dn !== e) begin
            $display("FAIL basic_done got=%h exp=%h", dn, e);
            failures++;
        end
        e = exp_act(10);
        checks++;
        if (ac !== e) begin
            $display("FAIL basic_active got=%h exp=%h", ac, e);
            failures++;
        end
    endtask

    task automatic test_parity;
        logic [55:0] sv, dn, ac, rv, e;
        logic acc;
        // even parity on 0xA5 -> parity bit 0
        capture(1, 8'hA5, -1, 8'h00, sv, dn, ac, rv, acc);
        e = exp_ser(16'h054A, 11);
        checks++;
        if (sv !== e) begin
            $display("FAIL even_line got=%h exp=%h", sv, e);
            failures++;
        end
        e = exp_done(11);
        checks++;
        if (dn !== e) begin
            $display("FAIL even_done got=%h exp=%h", dn, e);
            failures++;
        end
        // odd parity on 0xA5 -> parity bit 1
        capture(2, 8'hA5, -1, 8'h00, sv, dn, ac, rv, acc);
        e = exp_ser(16'h074A, 11);
        checks++;
        if (sv !== e) begin
            $display("FAIL odd_line got=%h exp=%h", sv, e);
            failures++;
        end
        e = exp_done(11);
        checks++;
        if (dn !== e) begin
            $display("FAIL odd_done got=%h exp=%h", dn, e);
            failures++;
        end
        e = exp_act(11);
        checks++;
        if (ac !== e) begin
            $display("FAIL odd_active got=%h exp=%h", ac, e);
            failures++;
        end
    endtask

    task automatic test_7bit_2stop;
        logic [55:0] sv, dn, ac, rv, e;
        logic acc;
        capture(3, 8'h7F, -1, 8'h00, sv, dn, ac, rv, acc);
        e = exp_ser(16'h03FE, 10);
        checks++;
        if (sv !== e) begin
            $display("FAIL b7s2_line got=%h exp=%h", sv, e);
            failures++;
        end
        e = exp_done(10);
        checks++;
        if (dn !== e) begin
            $display("FAIL b7s2_done got=%h exp=%h", dn, e);
            failures++;
        end
        e = exp_act(10);
        checks++;
        if (ac !== e) begin
            $display("FAIL b7s2_active got=%h exp=%h", ac, e);
            failures++;
        end
    endtask

    task automatic test_reset_midframe;
        logic [55:0] sv, dn, ac, rv, e;
        logic acc;
        logic seen_done;
        logic line_hi;
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy[0] && w < 200) begin
            @(negedge clk);
            w++;
        end
        dv[0] = 1'b1;
        tx_byte = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        dv[0] = 1'b0;
        // land in data bit 3 of 0xA5, which is a 0 on the line
        repeat (LAT + 17) @(negedge clk);
        checks++;
        if (ser[0] !== 1'b0 || act[0] !== 1'b1) begin
            $display("FAIL midframe_pre ser=%b act=%b exp ser=0 act=1",
                     ser[0], act[0]);
            failures++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ser[0] !== 1'b1) begin
            $display("FAIL abort_serial got=%b exp=1", ser[0]);
            failures++;
        end
        checks++;
        if (act[0] !== 1'b0 || done[0] !== 1'b0) begin
            $display("FAIL abort_act_done act=%b done=%b exp=0",
                     act[0], done[0]);
            failures++;
        end
        checks++;
        if (rdy[0] !== 1'b0) begin
            $display("FAIL abort_ready got=%b exp=0", rdy[0]);
            failures++;
        end
        seen_done = 1'b0;
        line_hi = 1'b1;
        @(negedge clk);
        seen_done = seen_done | done[0];
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen_done = seen_done | done[0];
            line_hi = line_hi & ser[0];
        end
        checks++;
        if (seen_done !== 1'b0) begin
            $display("FAIL abort_no_done got=%b exp=0", seen_done);
            failures++;
        end
        checks++;
        if (line_hi !== 1'b1) begin
            $display("FAIL abort_line_idle got=%b exp=1", line_hi);
            failures++;
        end
        // next word 0xC3 must go out normally
        capture(0, 8'hC3, -1, 8'h00, sv, dn, ac, rv, acc);
        checks++;
        if (acc !== 1'b1) begin
            $display("FAIL after_abort_accept got=%b exp=1", acc);
            failures++;
        end
        e = exp_ser(16'h0386, 10);
        checks++;
        if (sv !== e) begin
            $display("FAIL after_abort_line got=%h exp=%h", sv, e);
            failures++;
        end
        e = exp_done(10);
        checks++;
        if (dn !== e) begin
            $display("FAIL after_abort_done got=%h exp=%h", dn, e);
            failures++;
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_burst;
        logic [7:0] words [6];
        logic [5:0] rdy_obs;
        logic [239:0] line;
        int pos, nfr, s;
        logic [7:0] d;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    rdy_obs[i] = rdy[0];
                    dv[0] = 1'b1;
                    tx_byte = words[i];
                    @(negedge clk);
                end
                dv[0] = 1'b0;
            end
            begin
                for (int t = 0; t < 240; t++) begin
                    line[t] = ser[0];
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (rdy_obs !== 6'b011111) begin
            $display("FAIL fifo_ready got=%b exp=011111", rdy_obs);
            failures++;
        end
        pos = 0;
        nfr = 0;
        while (pos < 200) begin
            if (line[pos] == 1'b0) begin
                s = pos;
                for (int b = 0; b < 8; b++) begin
                    d[b] = line[s + CPB * (b + 1) + 2];
                end
                if (nfr < 5) begin
                    checks++;
                    if (d !== words[nfr] || s != 2 + 42 * nfr ||
                        line[s + 38] !== 1'b1) begin
                        $display("FAIL fifo_frame%0d data=%h at=%0d exp=%h at %0d",
                                 nfr, d, s, words[nfr], 2 + 42 * nfr);
                        failures++;
                    end
                end
                nfr++;
                pos = s + 40;
            end else begin
                pos++;
            end
        end
        checks++;
        if (nfr != 5) begin
            $display("FAIL fifo_frame_count got=%0d exp=5", nfr);
            failures++;
        end
    endtask
`else
    task automatic test_ignore_midframe;
        logic [55:0] sv, dn, ac, rv, e;
        logic acc;
        capture(0, 8'hA5, 10, 8'h3C, sv, dn, ac, rv, acc);
        checks++;
        if (rv[10] !== 1'b0) begin
            $display("FAIL midframe_ready got=%b exp=0", rv[10]);
            failures++;
        end
        e = exp_ser(16'h034A, 10);
        checks++;
        if (sv !== e) begin
            $display("FAIL ignore_line got=%h exp=%h", sv, e);
            failures++;
        end
        e = exp_act(10);
        checks++;
        if (ac !== e) begin
            $display("FAIL ignore_active got=%h exp=%h", ac, e);
            failures++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_7bit_2stop();
        test_reset_midframe();
`ifdef UART_TX_FIFO_EN
        test_fifo_burst();
`else
        test_ignore_midframe();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
